// File: rtl/clk_pkg.sv
// clk_pkg: shared repeat-FSM encoding and BCD/12h display helpers for the clock datapath
package clk_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RPT} rep_state_t;
  function automatic logic [7:0] bin2bcd2(input logic [6:0] v);
    logic [6:0] t;
    t = v / 7'd10;
    return {t[3:0], 4'(v - t * 7'd10)};
  endfunction
  function automatic logic [6:0] to12h(input logic [6:0] v);
    return v == 7'd0 ? 7'd12 : v > 7'd12 ? v - 7'd12 : v;
  endfunction
endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: turns held INC/DEC levels into single-cycle step pulses with delayed auto-repeat
module btn_repeat import clk_pkg::*; #(
  parameter int REP_DLY = 5,
  parameter int REP_DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic INC,
  input  logic DEC,
  input  logic TICK,
  output logic step_up,
  output logic step_dn
);
  rep_state_t st, st_n;
  logic up, up_n, inc_q, dec_q, act;
  logic [15:0] tcnt, tcnt_n, tnext;
  assign act = up ? INC : DEC;
  assign tnext = tcnt + 16'd1;
  always_comb begin
    st_n = st;
    up_n = up;
    tcnt_n = tcnt;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (INC && DEC) begin
      st_n = IDLE;
      tcnt_n = '0;
    end else if (st == IDLE) begin
      if (INC && !inc_q) begin
        st_n = WAIT;
        up_n = 1'b1;
        step_up = 1'b1;
        tcnt_n = '0;
      end else if (DEC && !dec_q) begin
        st_n = WAIT;
        up_n = 1'b0;
        step_dn = 1'b1;
        tcnt_n = '0;
      end
    end else if (!act) begin
      st_n = IDLE;
      tcnt_n = '0;
    end else if (TICK) begin
      if (tnext == 16'(st == WAIT ? REP_DLY : REP_DIV)) begin
        st_n = RPT;
        tcnt_n = '0;
        step_up = up;
        step_dn = !up;
      end else tcnt_n = tnext;
    end
  end
  // edge-detect flops track the buttons even in reset so a button held through reset does not step
  always_ff @(posedge CLK) begin
    inc_q <= INC;
    dec_q <= DEC;
    if (RST) begin
      st <= IDLE;
      up <= 1'b1;
      tcnt <= '0;
    end else begin
      st <= st_n;
      up <= up_n;
      tcnt <= tcnt_n;
    end
  end
endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: modulo-N carry-chained counter with manual set, preset load and BCD / 12h display outputs
module bcd_mod_counter import clk_pkg::*; #(
  parameter int MODULUS = 24,
  parameter int REP_DLY = 5,
  parameter int REP_DIV = 2,
  parameter int EN_12H  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       INC,
  input  logic       DEC,
  input  logic       TICK,
  input  logic       LOAD,
  input  logic [3:0] LDH,
  input  logic [3:0] LDL,
  input  logic       MODE12,
  output logic [3:0] QH,
  output logic [3:0] QL,
  output logic       PM,
  output logic       CO,
  output logic       LDERR
);
  localparam int W = $clog2(MODULUS);
  localparam logic [W-1:0] MAX = W'(MODULUS - 1);
  logic [W-1:0] cnt, cnt_n;
  logic co_n, lderr_n, step_up, step_dn, m12, ld_ok;
  logic [7:0] ld_val;
  logic [6:0] disp;
  btn_repeat #(.REP_DLY(REP_DLY), .REP_DIV(REP_DIV)) u_rep (
    .CLK(CLK), .RST(RST), .INC(INC), .DEC(DEC), .TICK(TICK), .step_up(step_up), .step_dn(step_dn)
  );
  assign m12 = (EN_12H != 0) && (MODULUS == 24) && MODE12;
  assign ld_val = 8'(LDH) * 8'd10 + 8'(LDL);
  assign ld_ok = (LDL <= 4'd9) && (ld_val < 8'(MODULUS));
  assign disp = m12 ? to12h(7'(cnt)) : 7'(cnt);
  // a down step coinciding with EN cancels out; an up step merges with EN into one increment
  always_comb begin
    cnt_n = cnt;
    co_n = 1'b0;
    lderr_n = 1'b0;
    if (LOAD) begin
      cnt_n = ld_ok ? ld_val[W-1:0] : cnt;
      lderr_n = !ld_ok;
    end else if (step_dn) cnt_n = EN ? cnt : (cnt == '0 ? MAX : cnt - W'(1));
    else if (step_up || EN) begin
      cnt_n = cnt == MAX ? '0 : cnt + W'(1);
      co_n = EN && cnt == MAX;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      CO <= 1'b0;
      LDERR <= 1'b0;
      {QH, QL} <= m12 ? 8'h12 : 8'h00;
      PM <= 1'b0;
    end else begin
      cnt <= cnt_n;
      CO <= co_n;
      LDERR <= lderr_n;
      {QH, QL} <= bin2bcd2(disp);
      PM <= m12 && 7'(cnt) >= 7'd12;
    end
  end
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: directed + random stimulus on a mod-24 and a mod-60 instance against an arithmetic model
module tb_bcd_mod_counter;
  localparam int REP_DLY = 5;
  localparam int REP_DIV = 2;
  logic CLK = 1'b0;
  logic rst, en, inc, dec, tick, load, mode12;
  logic [3:0] ldh, ldl;
  logic [3:0] qh [2];
  logic [3:0] ql [2];
  logic pm [2];
  logic co [2];
  logic lderr [2];
  int checks = 0, errors = 0;
  int mods [2] = '{24, 60};
  int cnt [2], e_qh [2], e_ql [2], e_pm [2], e_co [2], e_le [2];
  int held = 0, ticks = 0;
  bit pinc = 0, pdec = 0;

  always #5 CLK = ~CLK;

  bcd_mod_counter #(.MODULUS(24), .REP_DLY(REP_DLY), .REP_DIV(REP_DIV), .EN_12H(1)) d0 (
    .CLK(CLK), .RST(rst), .EN(en), .INC(inc), .DEC(dec), .TICK(tick), .LOAD(load), .LDH(ldh), .LDL(ldl),
    .MODE12(mode12), .QH(qh[0]), .QL(ql[0]), .PM(pm[0]), .CO(co[0]), .LDERR(lderr[0])
  );
  bcd_mod_counter #(.MODULUS(60), .REP_DLY(REP_DLY), .REP_DIV(REP_DIV), .EN_12H(1)) d1 (
    .CLK(CLK), .RST(rst), .EN(en), .INC(inc), .DEC(dec), .TICK(tick), .LOAD(load), .LDH(ldh), .LDL(ldl),
    .MODE12(mode12), .QH(qh[1]), .QL(ql[1]), .PM(pm[1]), .CO(co[1]), .LDERR(lderr[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // one clock: apply model for the edge, then compare all outputs 1ns after it
  task automatic clk_cycle();
    int s, h, v, d;
    @(posedge CLK);
    s = 0;
    if (rst || (inc && dec)) held = 0;
    else if (held != 0) begin
      if ((held > 0 ? inc : dec) == 1'b0) held = 0;
      else if (tick) begin
        ticks++;
        if (ticks >= REP_DLY && (ticks - REP_DLY) % REP_DIV == 0) s = held;
      end
    end else if (inc && !pinc) begin
      held = 1; ticks = 0; s = 1;
    end else if (dec && !pdec) begin
      held = -1; ticks = 0; s = -1;
    end
    pinc = inc;
    pdec = dec;
    for (int i = 0; i < 2; i++) begin
      h = rst ? 0 : cnt[i];
      e_pm[i] = (i == 0 && mode12 && h >= 12) ? 1 : 0;
      if (i == 0 && mode12) begin
        h = h % 12;
        if (h == 0) h = 12;
      end
      e_qh[i] = h / 10;
      e_ql[i] = h % 10;
      e_co[i] = 0;
      e_le[i] = 0;
      if (rst) cnt[i] = 0;
      else if (load) begin
        v = ldh * 10 + ldl;
        if (ldl <= 9 && v < mods[i]) cnt[i] = v;
        else e_le[i] = 1;
      end else begin
        d = en ? (s < 0 ? 0 : 1) : s;
        e_co[i] = (en && s >= 0 && cnt[i] == mods[i] - 1) ? 1 : 0;
        cnt[i] = (cnt[i] + d + mods[i]) % mods[i];
      end
    end
    #1;
    check("qh0", 32'(qh[0]), 32'(e_qh[0]));
    check("ql0", 32'(ql[0]), 32'(e_ql[0]));
    check("pm0", 32'(pm[0]), 32'(e_pm[0]));
    check("co0", 32'(co[0]), 32'(e_co[0]));
    check("lderr0", 32'(lderr[0]), 32'(e_le[0]));
    check("qh1", 32'(qh[1]), 32'(e_qh[1]));
    check("ql1", 32'(ql[1]), 32'(e_ql[1]));
    check("pm1", 32'(pm[1]), 32'(e_pm[1]));
    check("co1", 32'(co[1]), 32'(e_co[1]));
    check("lderr1", 32'(lderr[1]), 32'(e_le[1]));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) clk_cycle();
  endtask

  task automatic do_load(input int h, input int l);
    ldh = 4'(h);
    ldl = 4'(l);
    load = 1'b1;
    run(1);
    load = 1'b0;
    run(1);
  endtask

  initial begin
    rst = 1; en = 0; inc = 0; dec = 0; tick = 0; load = 0; mode12 = 0; ldh = 0; ldl = 0;
    run(2);
    rst = 0;
    run(1);
    en = 1;
    run(24);
    en = 0;
    run(2);
    mode12 = 1;
    do_load(0, 0);
    do_load(1, 1);
    do_load(1, 2);
    do_load(1, 3);
    mode12 = 0;
    do_load(2, 5);
    do_load(1, 10);
    do_load(1, 7);
    do_load(0, 0);
    dec = 1; run(1); dec = 0; run(1);
    check("dec_wrap60", 32'({qh[1], ql[1]}), 32'h59);
    inc = 1; run(1); inc = 0; run(1);
    check("inc_wrap60", 32'({qh[1], ql[1]}), 32'h00);
    inc = 1; run(1);
    for (int k = 0; k < 15; k++) begin
      tick = 1; run(1);
      tick = 0; run(1);
    end
    inc = 0;
    run(1);
    check("rpt7", 32'({qh[0], ql[0]}), 32'h07);
    do_load(2, 3);
    en = 1; dec = 1; run(1); en = 0; dec = 0; run(1);
    en = 1; inc = 1; run(1); en = 0; inc = 0; run(1);
    inc = 1;
    for (int k = 0; k < 7; k++) begin
      tick = 1; run(1);
      tick = 0; run(1);
    end
    rst = 1; run(2);
    rst = 0; run(3);
    inc = 0;
    run(1);
    check("rst_mid_rpt", 32'({qh[0], ql[0]}), 32'h00);
    for (int k = 0; k < 4000; k++) begin
      en = ($urandom_range(2) == 0);
      tick = ($urandom_range(2) == 0);
      if ($urandom_range(11) == 0) inc = ~inc;
      if ($urandom_range(15) == 0) dec = ~dec;
      load = ($urandom_range(24) == 0);
      ldh = 4'($urandom_range(6));
      ldl = 4'($urandom_range(11));
      if ($urandom_range(49) == 0) mode12 = ~mode12;
      rst = ($urandom_range(299) == 0);
      run(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
